// File: rtl/fl_pkg.sv
// Shared types, sizes and helpers for the checkpointed physical-register free list.
package fl_pkg;

    localparam int PHY_REG_NUM  = 64;
    localparam int ARCH_REG_NUM = 32;
    localparam int ALLOC_WIDTH  = 4;
    localparam int FREE_WIDTH   = 4;
    localparam int CKPT_NUM     = 8;
    localparam int PW           = $clog2(PHY_REG_NUM);
    localparam int CKPT_ID_W    = $clog2(CKPT_NUM);
    localparam int LANE_W       = (ALLOC_WIDTH > FREE_WIDTH) ? ALLOC_WIDTH : FREE_WIDTH;
    localparam int INIT_FREE    = PHY_REG_NUM - ARCH_REG_NUM;

    typedef logic [PW-1:0]        preg_t;
    typedef logic [PW:0]          fl_ptr_t;
    typedef logic [CKPT_ID_W-1:0] ckpt_id_t;

    // Number of set lanes; also correct for the non-contiguous commit mask
    function automatic fl_ptr_t popcount_contig(input logic [LANE_W-1:0] v);
        fl_ptr_t cnt;
        cnt = '0;
        for (int i = 0; i < LANE_W; i++) begin
            cnt = cnt + fl_ptr_t'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ckpt_free_list_chk.sv
// Simulation-only checks on the free list occupancy.
module ckpt_free_list_chk
    import fl_pkg::*;
(
    input logic    clk,
    input logic    rst_n,
    input fl_ptr_t free_cnt
);

    // The list can never hold more than the pregs not owned by the arch map
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        free_cnt <= fl_ptr_t'(INIT_FREE));

endmodule

// File: rtl/fl_ckpt_table.sv
// Checkpoint slots holding snapshots of the free-list head: one write port, one async read port.
module fl_ckpt_table
    import fl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     we,
    input  ckpt_id_t waddr,
    input  fl_ptr_t  wdata,
    input  ckpt_id_t raddr,
    output fl_ptr_t  rdata
);

    fl_ptr_t slot_r [CKPT_NUM];

    // Slot storage, written on a checkpoint take
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CKPT_NUM; i++) begin
                slot_r[i] <= '0;
            end
        end else if (we) begin
            slot_r[waddr] <= wdata;
        end
    end

    assign rdata = slot_r[raddr];

endmodule

// File: rtl/ckpt_free_list.sv
// Physical-register free list: circular FIFO with per-branch head checkpoints and an arch head for flush.
// Perf outputs stall_cnt_o / min_free_o are only built when FREE_LIST_PERF_EN is defined.
module ckpt_free_list
    import fl_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic [ALLOC_WIDTH-1:0]         alloc_valid_i,
    output logic                           alloc_ready_o,
    output logic [ALLOC_WIDTH-1:0][PW-1:0] preg_o,
    input  logic [FREE_WIDTH-1:0]          free_valid_i,
    input  logic [FREE_WIDTH-1:0][PW-1:0]  free_preg_i,
    output logic                           free_ready_o,
    input  logic [FREE_WIDTH-1:0]          commit_dst_i,
    input  logic                           ckpt_take_i,
    input  logic [CKPT_ID_W-1:0]           ckpt_id_i,
    input  logic                           ckpt_restore_i,
    input  logic [CKPT_ID_W-1:0]           ckpt_rst_id_i,
    output logic [PW:0]                    free_cnt_o,
    output logic [31:0]                    stall_cnt_o,
    output logic [PW:0]                    min_free_o
);

    preg_t   entry_r [PHY_REG_NUM];
    fl_ptr_t head_r, tail_r, arch_head_r, free_cnt_r;
    logic    ready_r;

    fl_ptr_t ckpt_rdata_s, alloc_head_s, arch_head_nxt_s, head_nxt_s, tail_nxt_s, cnt_nxt_s;
    logic    fire_s, take_s;

    assign free_ready_o  = 1'b1;
    assign alloc_ready_o = ready_r;
    assign free_cnt_o    = free_cnt_r;

    // Next pointer values; flush beats restore beats alloc
    always_comb begin
        fire_s = ready_r & (|alloc_valid_i) & ~flush_i & ~ckpt_restore_i;
        take_s = ckpt_take_i & ~flush_i & ~ckpt_restore_i;
        if (fire_s) begin
            alloc_head_s = head_r + popcount_contig(alloc_valid_i);
        end else begin
            alloc_head_s = head_r;
        end
        arch_head_nxt_s = arch_head_r + popcount_contig(commit_dst_i & free_valid_i);
        tail_nxt_s      = tail_r + popcount_contig(free_valid_i);
        if (flush_i) begin
            head_nxt_s = arch_head_nxt_s;
        end else if (ckpt_restore_i) begin
            head_nxt_s = ckpt_rdata_s;
        end else begin
            head_nxt_s = alloc_head_s;
        end
        cnt_nxt_s = tail_nxt_s - head_nxt_s;
    end

    // Allocation read-out: lanes are offered even when not ready, consumer qualifies with ready
    always_comb begin
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            if (alloc_valid_i[k]) begin
                preg_o[k] = entry_r[preg_t'(head_r[PW-1:0] + preg_t'(k))];
            end else begin
                preg_o[k] = '0;
            end
        end
    end

    // List storage; freed pregs land at tail+lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHY_REG_NUM; i++) begin
                entry_r[i] <= (i < INIT_FREE) ? preg_t'(ARCH_REG_NUM + i) : '0;
            end
        end else begin
            for (int k = 0; k < FREE_WIDTH; k++) begin
                if (free_valid_i[k]) begin
                    entry_r[preg_t'(tail_r[PW-1:0] + preg_t'(k))] <= free_preg_i[k];
                end
            end
        end
    end

    // Pointer, occupancy and ready registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r      <= '0;
            arch_head_r <= '0;
            tail_r      <= fl_ptr_t'(INIT_FREE);
            free_cnt_r  <= fl_ptr_t'(INIT_FREE);
            ready_r     <= (fl_ptr_t'(INIT_FREE) >= fl_ptr_t'(ALLOC_WIDTH));
        end else begin
            head_r      <= head_nxt_s;
            arch_head_r <= arch_head_nxt_s;
            tail_r      <= tail_nxt_s;
            free_cnt_r  <= cnt_nxt_s;
            ready_r     <= (cnt_nxt_s >= fl_ptr_t'(ALLOC_WIDTH));
        end
    end

    // Snapshot is the post-alloc head so the branch keeps its own destination
    fl_ckpt_table u_ckpt (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (take_s),
        .waddr (ckpt_id_i),
        .wdata (alloc_head_s),
        .raddr (ckpt_rst_id_i),
        .rdata (ckpt_rdata_s)
    );

    ckpt_free_list_chk u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .free_cnt (free_cnt_r)
    );

`ifdef FREE_LIST_PERF_EN
    logic [31:0] stall_cnt_r;
    fl_ptr_t     min_free_r;

    // Stall counter (saturating) and low watermark of occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
            min_free_r  <= fl_ptr_t'(INIT_FREE);
        end else begin
            if ((|alloc_valid_i) && !ready_r && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (free_cnt_r < min_free_r) begin
                min_free_r <= free_cnt_r;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign min_free_o  = min_free_r;
`else
    assign stall_cnt_o = '0;
    assign min_free_o  = '0;
`endif

endmodule

// File: tb/tb_ckpt_free_list.sv
// Scoreboard bench for ckpt_free_list: directed scenarios then random traffic against an
// unbounded-sequence reference model (absolute positions, no wrap).
module tb_ckpt_free_list;
    import fl_pkg::*;

    logic             clk, rst_n, flush_i, alloc_ready_o, free_ready_o;
    logic             ckpt_take_i, ckpt_restore_i;
    logic [3:0]       alloc_valid_i, free_valid_i, commit_dst_i;
    logic [3:0][5:0]  preg_o, free_preg_i;
    logic [2:0]       ckpt_id_i, ckpt_rst_id_i;
    logic [6:0]       free_cnt_o, min_free_o;
    logic [31:0]      stall_cnt_o;

    ckpt_free_list dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .preg_o(preg_o),
        .free_valid_i(free_valid_i), .free_preg_i(free_preg_i), .free_ready_o(free_ready_o),
        .commit_dst_i(commit_dst_i), .ckpt_take_i(ckpt_take_i), .ckpt_id_i(ckpt_id_i),
        .ckpt_restore_i(ckpt_restore_i), .ckpt_rst_id_i(ckpt_rst_id_i),
        .free_cnt_o(free_cnt_o), .stall_cnt_o(stall_cnt_o), .min_free_o(min_free_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            rdy;
        logic [6:0]      fc;
        logic [3:0]      mask;
        logic [3:0][5:0] preg;
        logic [31:0]     stall;
        logic [6:0]      minf;
    } exp_t;

    exp_t sb_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model: absolute list positions, never wrapped
    int          seq [int];
    int          head_m, tail_m, arch_m, minf_m;
    int unsigned stall_m;
    int          ck_val [8];
    bit          ck_ok [8];
    logic [3:0][5:0] fp_g;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops one expectation per cycle, sampled mid-low-phase
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("alloc_ready", alloc_ready_o, e.rdy);
                check("free_cnt", free_cnt_o, e.fc);
                check("free_ready", free_ready_o, 1);
                for (int k = 0; k < 4; k++)
                    if (e.mask[k]) check($sformatf("preg[%0d]", k), preg_o[k], e.preg[k]);
                check("stall_cnt", stall_cnt_o, e.stall);
                check("min_free", min_free_o, e.minf);
            end
        end
    end

    function automatic logic [3:0] lanes(input int n);
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) if (k < n) v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        head_m = 0; arch_m = 0; tail_m = INIT_FREE;
        seq.delete();
        for (int i = 0; i < INIT_FREE; i++) seq[i] = ARCH_REG_NUM + i;
        for (int c = 0; c < 8; c++) ck_ok[c] = 1'b0;
        stall_m = 0; minf_m = INIT_FREE;
    endtask

    function automatic exp_t make_exp(input logic [3:0] av);
        exp_t e;
        int   fc;
        fc = tail_m - head_m;
        e = '0;
        e.rdy = (fc >= 4);
        e.fc  = 7'(fc);
        for (int k = 0; k < 4; k++)
            if (av[k] && (head_m + k < tail_m)) begin
                e.mask[k] = 1'b1;
                e.preg[k] = 6'(seq[head_m + k]);
            end
`ifdef FREE_LIST_PERF_EN
        e.stall = stall_m;
        e.minf  = 7'(minf_m);
`endif
        return e;
    endfunction

    task automatic step(input logic [3:0] av, input logic [3:0] fv, input logic fl,
                        input logic tk, input int tid, input logic rs, input int rid);
        exp_t e;
        int   fc, ahead;
        logic rdy;
        alloc_valid_i = av; free_valid_i = fv; commit_dst_i = fv; free_preg_i = fp_g;
        flush_i = fl; ckpt_take_i = tk; ckpt_id_i = 3'(tid);
        ckpt_restore_i = rs; ckpt_rst_id_i = 3'(rid);
        e = make_exp(av);
        sb_q.push_back(e);
        fc  = tail_m - head_m;
        rdy = (fc >= 4);
        ahead = head_m;
        if (rdy && av != 4'b0000 && !fl && !rs) ahead = head_m + $countones(av);
        for (int k = 0; k < 4; k++) if (fv[k]) seq[tail_m + k] = fp_g[k];
        arch_m += $countones(fv);
        if (tk && !fl && !rs) begin ck_val[tid] = ahead; ck_ok[tid] = 1'b1; end
        if (fl) begin
            head_m = arch_m;
            for (int c = 0; c < 8; c++) ck_ok[c] = 1'b0;
        end else if (rs) head_m = ck_val[rid];
        else head_m = ahead;
        tail_m += $countones(fv);
        if (av != 4'b0000 && !rdy && stall_m != 32'hFFFF_FFFF) stall_m++;
        if (fc < minf_m) minf_m = fc;
        for (int k = 0; k < 4; k++) fp_g[k] = 6'($urandom_range(0, 63));
        @(negedge clk);
    endtask

    task automatic do_reset(input int cyc);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < cyc; i++) begin
            sb_q.push_back(make_exp(alloc_valid_i));
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int n, nf, maxc, rid, arch_next;
        logic fl, rs;
        rst_n = 1'b0; flush_i = 1'b0; alloc_valid_i = '0; free_valid_i = '0; commit_dst_i = '0;
        free_preg_i = '0; ckpt_take_i = 1'b0; ckpt_id_i = '0; ckpt_restore_i = 1'b0;
        ckpt_rst_id_i = '0; fp_g = '0;
        @(negedge clk);
        do_reset(2);

        // reset release then 4-lane alloc: 32..35
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);
        // 2-lane alloc alongside 2 frees of 5,6
        fp_g[0] = 6'd5; fp_g[1] = 6'd6;
        step(4'b0011, 4'b0011, 1'b0, 1'b0, 0, 1'b0, 0);
        // drain to exactly 3 free, stall, then one free
        while (tail_m - head_m >= 4) begin
            n = tail_m - head_m - 3;
            if (n > 4) n = 4;
            step(lanes(n), 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);
        end
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);
        step(4'b1111, 4'b0001, 1'b0, 1'b0, 0, 1'b0, 0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);
        // refill, take ckpt 2 with a 1-lane alloc, alloc 8, restore, re-alloc
        repeat (6) step(4'b0000, 4'b1111, 1'b0, 1'b0, 0, 1'b0, 0);
        step(4'b0001, 4'b0000, 1'b0, 1'b1, 2, 1'b0, 0);
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b1, 2);
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);
        // commit 2 and flush in the same cycle
        step(4'b0000, 4'b0011, 1'b1, 1'b0, 0, 1'b0, 0);
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);

        // random traffic; runs pointers around the ring many times
        for (int c = 0; c < 800; c++) begin
            maxc = head_m - arch_m;
            if (maxc > 4) maxc = 4;
            nf = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, maxc);
            arch_next = arch_m + nf;
            fl = ($urandom_range(0, 29) == 0);
            rs = 1'b0;
            rid = $urandom_range(0, 7);
            if (!fl && $urandom_range(0, 7) == 0 && ck_ok[rid] && ck_val[rid] >= arch_next) rs = 1'b1;
            step(lanes($urandom_range(0, 4)), lanes(nf), fl,
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 7), rs, rid);
        end

        // reset in the middle of a burst
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);
        alloc_valid_i = 4'b1111; free_valid_i = 4'b0011; commit_dst_i = 4'b0011;
        do_reset(2);
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);
        step(4'b0111, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0);

        #3;
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
